// File: rtl/alu_pkg.sv
// Shared definitions for the i16 ALU execute path: operation encodings
// and the state type used by the multi-cycle units.
package alu_pkg;

    localparam logic [1:0] OP_NEG  = 2'b00;
    localparam logic [1:0] OP_ABS  = 2'b01;
    localparam logic [1:0] OP_NOT  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/negator_digit.sv
// One DIGIT-bit slice of the serial negator: conditionally inverts the
// digit and adds the incoming carry, producing the sum digit and carry-out.
module negator_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] digit,
    input  logic             invert,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT-1:0] operand;
    logic [DIGIT:0]   total;

    // Ones-complement the digit when requested, then ripple in the carry;
    // the extra top bit of the widened sum is the carry into the next digit.
    always_comb begin
        operand = digit ^ {DIGIT{invert}};
        total   = {1'b0, operand} + {{DIGIT{1'b0}}, cin};
        sum     = total[DIGIT-1:0];
        cout    = total[DIGIT];
    end

endmodule

// File: rtl/serial_negator.sv
// Multi-cycle NEG/ABS/NOT/PASS unit. The operand is consumed DIGIT bits per
// cycle, LSB first, through a single time-multiplexed negator_digit slice.
// The result only becomes visible when the last digit lands, so a reset or
// a half-finished operation never exposes a partial value on r.
module serial_negator
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_DIGIT = CW'(N - 1);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     acc;
    logic                 inv;
    logic                 carry;
    logic                 ovf_pend;

    logic                 accept_inv;
    logic                 accept_cin;
    logic                 accept_ovf;
    logic                 last;
    logic [DIGIT-1:0]     dsum;
    logic                 dcout;
    logic [WIDTH+DIGIT-1:0] shifted;

    negator_digit #(.DIGIT(DIGIT)) u_digit (
        .digit  (opnd[DIGIT-1:0]),
        .invert (inv),
        .cin    (carry),
        .sum    (dsum),
        .cout   (dcout)
    );

    // New sum digit enters at the top of the result register; after N
    // shifts the first digit has reached the LSB position.
    assign shifted = {dsum, acc};
    assign last    = (cnt == LAST_DIGIT);

    // Decode invert / carry-in / overflow for the operation being accepted.
    // The most-negative operand has no positive counterpart, so NEG and ABS
    // of it wrap back to itself and raise ovf.
    always_comb begin
        accept_inv = 1'b0;
        accept_cin = 1'b0;
        case (op)
            OP_NEG: begin
                accept_inv = 1'b1;
                accept_cin = 1'b1;
            end
            OP_ABS: begin
                accept_inv = a[WIDTH-1];
                accept_cin = a[WIDTH-1];
            end
            OP_NOT: begin
                accept_inv = 1'b1;
                accept_cin = 1'b0;
            end
            default: begin
                accept_inv = 1'b0;
                accept_cin = 1'b0;
            end
        endcase
        accept_ovf = ((op == OP_NEG) || (op == OP_ABS)) && (a == MOST_NEG);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, decoded from the registered state
    // only so neither ready nor valid depends combinationally on an input.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch the operand on accept, then walk one digit per RUN
    // cycle. r/ovf are written only on the final digit and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            inv      <= 1'b0;
            carry    <= 1'b0;
            ovf_pend <= 1'b0;
            r        <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd     <= a;
                        inv      <= accept_inv;
                        carry    <= accept_cin;
                        ovf_pend <= accept_ovf;
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                RUN: begin
                    opnd  <= opnd >> DIGIT;
                    acc   <= shifted[WIDTH+DIGIT-1:DIGIT];
                    carry <= dcout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        r   <= shifted[WIDTH+DIGIT-1:DIGIT];
                        ovf <= ovf_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negator.sv
// Directed and randomised checks of serial_negator at 4/1, 16/4 and 8/2.
module tb_serial_negator;

    logic clk;
    logic rst;

    logic        iv4, ir4, ov4, or4, f4;
    logic [1:0]  op4;
    logic [3:0]  a4, r4;

    logic        iv16, ir16, ov16, or16, f16;
    logic [1:0]  op16;
    logic [15:0] a16, r16;

    logic        iv8, ir8, ov8, or8, f8;
    logic [1:0]  op8;
    logic [7:0]  a8, r8;

    int tests;
    int fails;

    serial_negator #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4),
        .out_valid(ov4), .out_ready(or4), .r(r4), .ovf(f4)
    );

    serial_negator #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16),
        .out_valid(ov16), .out_ready(or16), .r(r16), .ovf(f16)
    );

    serial_negator #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8),
        .out_valid(ov8), .out_ready(or8), .r(r8), .ovf(f8)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {ovf, result} for an operand of width w.
    function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] av, input int w);
        logic [15:0] mask, mn, neg, res;
        logic        f;
        mask = 16'((32'h1 << w) - 1);
        mn   = 16'(32'h1 << (w - 1));
        av   = av & mask;
        neg  = (16'd0 - av) & mask;
        case (o)
            2'b00:   res = neg;
            2'b01:   res = ((av & mn) != 16'd0) ? neg : av;
            2'b10:   res = (~av) & mask;
            default: res = av;
        endcase
        f = ((o == 2'b00) || (o == 2'b01)) && (av == mn);
        return {f, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_ov(input int sel);
        case (sel)
            0:       return ov4;
            1:       return ov16;
            default: return ov8;
        endcase
    endfunction

    // Issue one operation on the selected instance (0=4/1, 1=16/4, 2=8/2),
    // wait for the result with a cycle bound, and return r, ovf and latency.
    task automatic applyStimulus(input int sel, input logic [1:0] o, input logic [15:0] av,
                                 output logic [15:0] rr, output logic ff, output int lat);
        @(negedge clk);
        case (sel)
            0: begin iv4 = 1'b1; op4 = o; a4 = av[3:0]; end
            1: begin iv16 = 1'b1; op16 = o; a16 = av; end
            default: begin iv8 = 1'b1; op8 = o; a8 = av[7:0]; end
        endcase
        @(posedge clk);
        #1;
        iv4 = 1'b0; iv16 = 1'b0; iv8 = 1'b0;
        a4 = 4'($urandom); a16 = 16'($urandom); a8 = 8'($urandom);
        op4 = 2'($urandom); op16 = 2'($urandom); op8 = 2'($urandom);
        lat = 0;
        while (!sel_ov(sel) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!sel_ov(sel)) begin
            checkOutput("timeout", 32'(lat), 32'd999);
        end
        case (sel)
            0:       begin rr = {12'd0, r4}; ff = f4; end
            1:       begin rr = r16; ff = f16; end
            default: begin rr = {8'd0, r8}; ff = f8; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rr;
        logic        ff;
        int          lat;
        logic [16:0] expv;
        logic [1:0]  ro;
        logic [15:0] ra;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        iv4 = 1'b0; iv16 = 1'b0; iv8 = 1'b0;
        op4 = 2'b00; op16 = 2'b00; op8 = 2'b00;
        a4 = '0; a16 = '0; a8 = '0;
        or4 = 1'b1; or16 = 1'b1; or8 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(ir16), 32'd1);
        checkOutput("reset_out_valid", 32'(ov16), 32'd0);
        checkOutput("reset_r", 32'(r16), 32'd0);
        checkOutput("reset_ovf", 32'(f16), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 4/1 directed cases.
        applyStimulus(0, 2'b00, 16'h000F, rr, ff, lat);
        checkOutput("w4_neg_m1_r", 32'(rr), 32'h1);
        checkOutput("w4_neg_m1_ovf", 32'(ff), 32'd0);
        checkOutput("w4_neg_m1_latency", 32'(lat), 32'd4);
        applyStimulus(0, 2'b00, 16'h0008, rr, ff, lat);
        checkOutput("w4_neg_min_r", 32'(rr), 32'h8);
        checkOutput("w4_neg_min_ovf", 32'(ff), 32'd1);
        applyStimulus(0, 2'b01, 16'h0008, rr, ff, lat);
        checkOutput("w4_abs_min_r", 32'(rr), 32'h8);
        checkOutput("w4_abs_min_ovf", 32'(ff), 32'd1);
        applyStimulus(0, 2'b00, 16'h0007, rr, ff, lat);
        checkOutput("w4_neg_7_r", 32'(rr), 32'h9);
        checkOutput("w4_neg_7_ovf", 32'(ff), 32'd0);

        // 16/4 directed cases.
        applyStimulus(1, 2'b01, 16'hFFFB, rr, ff, lat);
        checkOutput("w16_abs_m5_r", 32'(rr), 32'h0005);
        checkOutput("w16_abs_m5_ovf", 32'(ff), 32'd0);
        checkOutput("w16_latency", 32'(lat), 32'd4);
        applyStimulus(1, 2'b01, 16'h0005, rr, ff, lat);
        checkOutput("w16_abs_5_r", 32'(rr), 32'h0005);
        checkOutput("w16_abs_5_ovf", 32'(ff), 32'd0);
        applyStimulus(1, 2'b10, 16'h00FF, rr, ff, lat);
        checkOutput("w16_not_r", 32'(rr), 32'hFF00);
        checkOutput("w16_not_ovf", 32'(ff), 32'd0);
        applyStimulus(1, 2'b11, 16'h1234, rr, ff, lat);
        checkOutput("w16_pass_r", 32'(rr), 32'h1234);
        checkOutput("w16_pass_ovf", 32'(ff), 32'd0);
        applyStimulus(1, 2'b10, 16'h8000, rr, ff, lat);
        checkOutput("w16_not_min_ovf", 32'(ff), 32'd0);
        checkOutput("w16_not_min_r", 32'(rr), 32'h7FFF);

        // Backpressure: hold the result in DONE while in_valid pulses.
        or16 = 1'b0;
        applyStimulus(1, 2'b00, 16'h0003, rr, ff, lat);
        checkOutput("bp_r", 32'(rr), 32'hFFFD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv16 = 1'b1;
            op16 = 2'b11;
            a16  = 16'h5A5A + 16'(i);
            @(posedge clk);
            #1;
            checkOutput("bp_hold_r", 32'(r16), 32'hFFFD);
            checkOutput("bp_hold_ovf", 32'(f16), 32'd0);
            checkOutput("bp_hold_out_valid", 32'(ov16), 32'd1);
            checkOutput("bp_hold_in_ready", 32'(ir16), 32'd0);
        end
        @(negedge clk);
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_out_valid", 32'(ov16), 32'd0);
        checkOutput("bp_release_in_ready", 32'(ir16), 32'd1);
        checkOutput("bp_release_r_kept", 32'(r16), 32'hFFFD);

        // Reset mid-RUN after two of the four digits.
        @(negedge clk);
        iv16 = 1'b1;
        op16 = 2'b00;
        a16  = 16'h1234;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_r", 32'(r16), 32'd0);
        checkOutput("midrun_rst_ovf", 32'(f16), 32'd0);
        checkOutput("midrun_rst_out_valid", 32'(ov16), 32'd0);
        checkOutput("midrun_rst_in_ready", 32'(ir16), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 2'b00, 16'h0001, rr, ff, lat);
        checkOutput("post_rst_neg1_r", 32'(rr), 32'hFFFF);
        checkOutput("post_rst_neg1_ovf", 32'(ff), 32'd0);

        // Random regression at 16/4 and 8/2, biased towards the most-negative value.
        for (int i = 0; i < 1000; i++) begin
            int sel;
            int w;
            sel = (i % 2 == 0) ? 1 : 2;
            w   = (sel == 1) ? 16 : 8;
            ro  = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ra = (w == 16) ? 16'h8000 : 16'h0080;
            end
            if (w == 8) begin
                ra = ra & 16'h00FF;
            end
            expv = model(ro, ra, w);
            applyStimulus(sel, ro, ra, rr, ff, lat);
            checkOutput("rand_r", 32'(rr), 32'(expv[15:0]));
            checkOutput("rand_ovf", 32'(ff), 32'(expv[16]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
